// File: rtl/host_cmd_mstr.sv
// -----------------------------------------------------------------------------
// host_cmd_mstr
//
// Host-side UART command master for the DSO_dig command link.
//
// The transmitter sends a 24-bit command as three back-to-back 8N1 frames,
// high byte first. The receiver independently deserializes 8N1 response frames
// and presents each byte through a ready/clear handshake. Tx and Rx share no
// state except that an accepted command clears a stale resp_rdy.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   cmd          command word: [23:16] opcode, [15:8] byte 2, [7:0] byte 3
//   send_cmd     one-cycle start pulse; only honoured while the Tx side is idle
//   cmd_sent     high after the third stop bit, held until the next accepted send
//   TX           serial out, idles high
//   RX           serial in, asynchronous to clk
//   resp         last correctly framed response byte
//   resp_rdy     resp holds a byte that has not been acknowledged yet
//   clr_resp_rdy one-cycle acknowledge for resp_rdy
//
// Parameter
//   BAUD_CYCLES  clk cycles per bit period (>= 4)
// -----------------------------------------------------------------------------
module host_cmd_mstr #(
    parameter int BAUD_CYCLES = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        TX,
    input  logic        RX,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    input  logic        clr_resp_rdy
);

    // Baud counters run 0..BAUD_CYCLES-1.
    localparam int            CW        = $clog2(BAUD_CYCLES);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_CYCLES / 2 - 1);

    // =========================================================================
    // Transmitter
    // =========================================================================
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_SHIFT
    } tx_state_e;

    tx_state_e     tx_state_q, tx_state_d;
    logic [23:0]   tx_hold_q,  tx_hold_d;
    logic [9:0]    tx_shift_q, tx_shift_d;
    logic [CW-1:0] tx_baud_q,  tx_baud_d;
    logic [3:0]    tx_bit_q,   tx_bit_d;
    logic [1:0]    tx_byte_q,  tx_byte_d;
    logic          tx_q,       tx_d;
    logic          cmd_sent_q, cmd_sent_d;
    logic [7:0]    tx_sel;
    logic          send_acc;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_hold_d  = tx_hold_q;
        tx_shift_d = tx_shift_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_byte_d  = tx_byte_q;
        cmd_sent_d = cmd_sent_q;
        send_acc   = 1'b0;

        case (tx_byte_q)
            2'd0:    tx_sel = tx_hold_q[23:16];
            2'd1:    tx_sel = tx_hold_q[15:8];
            default: tx_sel = tx_hold_q[7:0];
        endcase

        case (tx_state_q)
            TX_IDLE: begin
                if (send_cmd) begin
                    send_acc   = 1'b1;
                    tx_hold_d  = cmd;
                    tx_byte_d  = 2'd0;
                    cmd_sent_d = 1'b0;
                    tx_state_d = TX_LOAD;
                end
            end
            TX_LOAD: begin
                // Frame is shifted out LSB first: start, data[0..7], stop.
                tx_shift_d = {1'b1, tx_sel, 1'b0};
                tx_baud_d  = '0;
                tx_bit_d   = '0;
                tx_state_d = TX_SHIFT;
            end
            TX_SHIFT: begin
                if (tx_baud_q == BAUD_LAST) begin
                    tx_baud_d  = '0;
                    tx_shift_d = {1'b1, tx_shift_q[9:1]};
                    if (tx_bit_q == 4'd9) begin
                        if (tx_byte_q == 2'd2) begin
                            cmd_sent_d = 1'b1;
                            tx_state_d = TX_IDLE;
                        end else begin
                            tx_byte_d  = tx_byte_q + 2'd1;
                            tx_state_d = TX_LOAD;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end else begin
                    tx_baud_d = tx_baud_q + CW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // TX is registered so the line never glitches; this adds one cycle of
        // latency uniformly to every bit, and the LOAD cycle between bytes is
        // seen on the line as a slightly longer stop bit.
        tx_d = (tx_state_q == TX_SHIFT) ? tx_shift_q[0] : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_hold_q  <= '0;
            tx_shift_q <= '1;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
            tx_q       <= 1'b1;
            cmd_sent_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_hold_q  <= tx_hold_d;
            tx_shift_q <= tx_shift_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_byte_q  <= tx_byte_d;
            tx_q       <= tx_d;
            cmd_sent_q <= cmd_sent_d;
        end
    end

    // =========================================================================
    // Receiver
    // =========================================================================
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Two-flop synchronizer plus one history flop for edge detection. All
    // reset to the idle (mark) level so reset release never looks like a start.
    logic          rx_sync1_q, rx_sync2_q, rx_prev_q;
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_baud_q,  rx_baud_d;
    logic [2:0]    rx_bit_q,   rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_ferr_q,  rx_ferr_d;
    logic [7:0]    resp_q,     resp_d;
    logic          resp_rdy_q, resp_rdy_d;
    logic          rx_fall;
    logic          rx_done;

    assign rx_fall = rx_prev_q & ~rx_sync2_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_baud_d  = rx_baud_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_ferr_d  = rx_ferr_q;
        resp_d     = resp_q;
        rx_done    = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_baud_d  = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Half a bit after the edge we are at the start-bit centre;
                // a line already back high was only a glitch.
                if (rx_baud_q == HALF_LAST) begin
                    rx_baud_d = '0;
                    rx_bit_d  = '0;
                    rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_baud_d = rx_baud_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_baud_q == BAUD_LAST) begin
                    rx_baud_d  = '0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_ferr_d  = 1'b0;
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_baud_d = rx_baud_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_ferr_q) begin
                    // Framing error: hold off until the line returns to mark
                    // so the low stop bit is not mistaken for a new start.
                    if (rx_sync2_q) begin
                        rx_ferr_d  = 1'b0;
                        rx_state_d = RX_IDLE;
                    end
                end else if (rx_baud_q == BAUD_LAST) begin
                    if (rx_sync2_q) begin
                        resp_d     = rx_shift_q;
                        rx_done    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
                end else begin
                    rx_baud_d = rx_baud_q + CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        // A completing byte beats any clear in the same cycle.
        if (rx_done)
            resp_rdy_d = 1'b1;
        else if (clr_resp_rdy || send_acc)
            resp_rdy_d = 1'b0;
        else
            resp_rdy_d = resp_rdy_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_ferr_q  <= 1'b0;
            resp_q     <= 8'h00;
            resp_rdy_q <= 1'b0;
        end else begin
            rx_sync1_q <= RX;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_ferr_q  <= rx_ferr_d;
            resp_q     <= resp_d;
            resp_rdy_q <= resp_rdy_d;
        end
    end

    assign TX       = tx_q;
    assign cmd_sent = cmd_sent_q;
    assign resp     = resp_q;
    assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_host_cmd_mstr.sv
// -----------------------------------------------------------------------------
// tb_host_cmd_mstr
//
// Directed plus randomized bench for host_cmd_mstr. A behavioural UART decoder
// watches TX and queues whole bytes; an RX driver task builds 8N1 frames. The
// expected TX bytes come straight from the command word, and the expected
// resp/resp_rdy come from a two-variable model updated by the handshake rules.
// -----------------------------------------------------------------------------
module tb_host_cmd_mstr;

    localparam int B = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] cmd = '0;
    logic        send_cmd = 1'b0;
    logic        clr_resp_rdy = 1'b0;
    logic        RX = 1'b1;
    logic        cmd_sent;
    logic        TX;
    logic [7:0]  resp;
    logic        resp_rdy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model of the response side.
    logic [7:0] exp_resp = 8'h00;
    logic       exp_rdy  = 1'b0;

    host_cmd_mstr #(.BAUD_CYCLES(B)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd          (cmd),
        .send_cmd     (send_cmd),
        .cmd_sent     (cmd_sent),
        .TX           (TX),
        .RX           (RX),
        .resp         (resp),
        .resp_rdy     (resp_rdy),
        .clr_resp_rdy (clr_resp_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- TX line decoder ----------------
    logic [7:0] mon_byte_q[$];
    bit         mon_ok_q[$];
    int         mon_start_q[$];

    initial begin : tx_monitor
        int         t0;
        logic [7:0] b;
        bit         ok;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && TX === 1'b0) begin
                t0 = cyc;
                ok = 1'b1;
                repeat (B / 2) @(negedge clk);
                if (TX !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    b[i] = TX;
                end
                repeat (B) @(negedge clk);
                if (TX !== 1'b1) ok = 1'b0;
                mon_byte_q.push_back(b);
                mon_ok_q.push_back(ok);
                mon_start_q.push_back(t0);
            end
        end
    end

    // ---------------- resp_rdy rise tracker ----------------
    bit   saw_rdy = 1'b0;
    int   rdy_rise_cyc = 0;
    int   rx_start_cyc = 0;

    initial begin : rdy_monitor
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_rdy === 1'b1 && prev !== 1'b1) begin
                saw_rdy      = 1'b1;
                rdy_rise_cyc = cyc;
            end
            prev = resp_rdy;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_send(input logic [23:0] c);
        @(negedge clk);
        cmd      = c;
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
    endtask

    // Called at the negedge right after the accepting edge; returns how many
    // clocks later TX first went low and cmd_sent rose (bounded).
    task automatic wait_sent(output int fall_n, output int sent_n);
        int n;
        n      = 0;
        fall_n = -1;
        while (cmd_sent !== 1'b1 && n < 40 * B) begin
            if (TX === 1'b0 && fall_n < 0) fall_n = n;
            @(negedge clk);
            n++;
        end
        sent_n = n;
    endtask

    task automatic clear_mon();
        mon_byte_q.delete();
        mon_ok_q.delete();
        mon_start_q.delete();
    endtask

    // Compare decoded TX bytes against the command, check framing, spacing,
    // and that cmd_sent stays high afterwards.
    task automatic expect_tx(input logic [23:0] c);
        int t;
        int held;
        t = 0;
        while (mon_byte_q.size() < 3 && t < 4 * B) begin
            @(negedge clk);
            t++;
        end
        check("tx_nbytes", 32'(mon_byte_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < mon_byte_q.size(); i++) begin
            check("tx_byte", 32'(mon_byte_q[i]), 32'((c >> (16 - 8 * i)) & 24'hFF));
            check("tx_frame", 32'(mon_ok_q[i]), 32'd1);
        end
        for (int i = 1; i < 3 && i < mon_start_q.size(); i++) begin
            t = mon_start_q[i] - mon_start_q[i-1];
            check("tx_gap", 32'(t >= 10 * B && t <= 10 * B + 1), 32'd1);
        end
        held = 0;
        repeat (2 * B) begin
            @(negedge clk);
            if (cmd_sent === 1'b1 && TX === 1'b1) held++;
        end
        check("sent_hold", 32'(held), 32'(2 * B));
        check("tx_extra", 32'(mon_byte_q.size()), 32'd3);
        clear_mon();
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stopb);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        @(negedge clk);
        rx_start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            repeat (B) @(negedge clk);
        end
        RX = 1'b1;
        if (stopb) begin
            exp_resp = b;
            exp_rdy  = 1'b1;
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_resp_rdy = 1'b1;
        @(negedge clk);
        clr_resp_rdy = 1'b0;
        exp_rdy = 1'b0;
    endtask

    task automatic check_resp(input string tag);
        check({tag, "_rdy"},  32'(resp_rdy), 32'(exp_rdy));
        check({tag, "_resp"}, 32'(resp),     32'(exp_resp));
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int         fall_n, sent_n, bad, lat;
        logic [23:0] c;
        logic [7:0]  r0, r1;

        // Reset state, during and after reset.
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(TX), 32'd1);
        check("rst_sent", 32'(cmd_sent), 32'd0);
        check_resp("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_tx", 32'(TX), 32'd1);
        check("post_rst_sent", 32'(cmd_sent), 32'd0);
        check_resp("post_rst");
        bad = 0;
        repeat (10 * B) begin
            @(negedge clk);
            if (TX !== 1'b1) bad++;
        end
        check("tx_idle", 32'(bad), 32'd0);
        check("idle_frames", 32'(mon_byte_q.size()), 32'd0);

        // Basic command with timing.
        pulse_send(24'h082ABB);
        wait_sent(fall_n, sent_n);
        check("tx_fall_lat", 32'(fall_n), 32'd2);
        check("sent_lat", 32'(sent_n >= 30 * B + 3 && sent_n <= 30 * B + 5), 32'd1);
        expect_tx(24'h082ABB);

        // send_cmd while busy is ignored.
        pulse_send(24'h082ABB);
        repeat (15 * B) @(negedge clk);
        pulse_send(24'h09FFFF);
        wait_sent(fall_n, sent_n);
        check("busy_sent_lat", 32'(sent_n < 40 * B), 32'd1);
        expect_tx(24'h082ABB);

        // Next command: cmd_sent drops one clock after acceptance.
        pulse_send(24'h092AFF);
        check("sent_drop", 32'(cmd_sent), 32'd0);
        wait_sent(fall_n, sent_n);
        check("sent_lat2", 32'(sent_n >= 30 * B + 3 && sent_n <= 30 * B + 5), 32'd1);
        expect_tx(24'h092AFF);

        // Response path.
        rx_frame(8'hA5, 1'b1);
        check_resp("rx_a5");
        lat = rdy_rise_cyc - rx_start_cyc;
        check("rx_lat", 32'(lat >= 9 * B && lat <= 10 * B), 32'd1);
        pulse_clr();
        check_resp("clr");
        rx_frame(8'h38, 1'b1);
        check_resp("rx_38");
        pulse_clr();

        // Glitch shorter than half a bit.
        @(negedge clk);
        RX = 1'b0;
        repeat (B / 4) @(negedge clk);
        RX = 1'b1;
        repeat (2 * B) @(negedge clk);
        check_resp("glitch");

        // Framing error, then recovery.
        rx_frame(8'h5A, 1'b0);
        repeat (B) @(negedge clk);
        check_resp("ferr");
        rx_frame(8'hC3, 1'b1);
        check_resp("recover");

        // Overwrite while resp_rdy is still high.
        rx_frame(8'h7E, 1'b1);
        check_resp("overwrite");

        // Clear held high across completion: the set must still be visible.
        @(negedge clk);
        clr_resp_rdy = 1'b1;
        repeat (2) @(negedge clk);
        saw_rdy = 1'b0;
        rx_frame(8'h96, 1'b1);
        check("set_wins", 32'(saw_rdy), 32'd1);
        check("set_wins_resp", 32'(resp), 32'h96);
        clr_resp_rdy = 1'b0;
        exp_rdy = 1'b0;
        @(negedge clk);
        check_resp("after_clr_hold");

        // Accepted send clears a stale resp_rdy.
        rx_frame(8'h11, 1'b1);
        check_resp("pre_send");
        c = 24'($urandom);
        pulse_send(c);
        exp_rdy = 1'b0;
        check_resp("send_clr");
        wait_sent(fall_n, sent_n);
        expect_tx(c);

        // Randomized full duplex.
        for (int k = 0; k < 4; k++) begin
            c  = 24'($urandom);
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            fork
                begin
                    int fn, sn;
                    pulse_send(c);
                    wait_sent(fn, sn);
                    check("dup_sent_lat", 32'(sn >= 30 * B + 3 && sn <= 30 * B + 5), 32'd1);
                end
                begin
                    repeat (3) @(negedge clk);
                    exp_rdy = 1'b0;
                    rx_frame(r0, 1'b1);
                    check_resp("dup_r0");
                    rx_frame(r1, 1'b1);
                    check_resp("dup_r1");
                end
            join
            expect_tx(c);
            pulse_clr();
        end

        // Reset in the middle of both directions.
        rx_frame(8'h44, 1'b1);
        check_resp("pre_rst");
        fork
            pulse_send(24'h0100FF);
            rx_frame(8'h55, 1'b1);
        join_none
        repeat (5 * B) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_rdy  = 1'b0;
        exp_resp = 8'h00;
        check("midrst_tx", 32'(TX), 32'd1);
        check("midrst_sent", 32'(cmd_sent), 32'd0);
        check_resp("midrst");
        wait fork;
        exp_rdy  = 1'b0;
        exp_resp = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (12 * B) begin
            @(negedge clk);
            if (TX !== 1'b1 || cmd_sent !== 1'b0 || resp_rdy !== 1'b0) bad++;
        end
        check("postrst_quiet", 32'(bad), 32'd0);
        check_resp("postrst");
        clear_mon();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
